// File: rtl/shift_seq_unit.sv
// Multi-cycle shifter/rotator: LSR, LSL, ASR, ROR, ROL, up to STEP bit positions per clock.
// Optional SHIFT_CARRY_EN macro adds the Carry_OUT port (last bit shifted out).
module shift_seq_unit #(
  parameter  int DATA_WIDTH = 16,
  parameter  int STEP       = 1,
  localparam int SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic                  OP_SEL,
  input  logic [2:0]            ALU_FUN,
  input  logic [SHAMT_W-1:0]    SHAMT,
  input  logic                  Shift_Enable,
  output logic [DATA_WIDTH-1:0] Shift_OUT,
  output logic                  Shift_Flag,
`ifdef SHIFT_CARRY_EN
  output logic                  Carry_OUT,
`endif
  output logic                  Busy
);

  localparam logic [SHAMT_W-1:0] STEP_K = SHAMT_W'(STEP);

  localparam logic [2:0] FUN_LSR = 3'd0;
  localparam logic [2:0] FUN_LSL = 3'd1;
  localparam logic [2:0] FUN_ASR = 3'd2;
  localparam logic [2:0] FUN_ROR = 3'd3;
  localparam logic [2:0] FUN_ROL = 3'd4;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_work;
  logic [DATA_WIDTH-1:0] r_out;
  logic [2:0]            r_fun;
  logic [SHAMT_W-1:0]    r_rem;
  logic                  r_flag;
  logic                  r_busy;

  logic [DATA_WIDTH-1:0] w_operand;
  logic                  w_bypass;
  logic [SHAMT_W-1:0]    w_k;
  logic [SHAMT_W-1:0]    w_kneg;
  logic [SHAMT_W-1:0]    w_km1;
  logic                  w_last;
  logic [DATA_WIDTH-1:0] w_next;

  assign w_operand = OP_SEL ? B : A;
  assign w_bypass  = (SHAMT == '0) || (ALU_FUN > FUN_ROL);
  assign w_k       = (r_rem < STEP_K) ? r_rem : STEP_K;
  // In SHIFT w_k is never 0, so -w_k wraps to DATA_WIDTH-w_k (the rotate complement).
  assign w_kneg    = -w_k;
  assign w_km1     = w_k - 1'b1;
  assign w_last    = (r_rem <= STEP_K);

  always_comb begin
    w_next = r_work;
    case (r_fun)
      FUN_LSR: w_next = r_work >> w_k;
      FUN_LSL: w_next = r_work << w_k;
      FUN_ASR: w_next = $signed(r_work) >>> w_k;
      FUN_ROR: w_next = (r_work >> w_k) | (r_work << w_kneg);
      FUN_ROL: w_next = (r_work << w_k) | (r_work >> w_kneg);
      default: w_next = r_work;
    endcase
  end

`ifdef SHIFT_CARRY_EN
  logic r_carry;
  logic w_carry;

  // Only the final step's outgoing bit matters for the reported carry.
  assign w_carry = ((r_fun == FUN_LSL) || (r_fun == FUN_ROL)) ? r_work[w_kneg] : r_work[w_km1];
  assign Carry_OUT = r_carry;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_work  <= '0;
      r_out   <= '0;
      r_fun   <= '0;
      r_rem   <= '0;
      r_flag  <= 1'b0;
      r_busy  <= 1'b0;
`ifdef SHIFT_CARRY_EN
      r_carry <= 1'b0;
`endif
    end else begin
      r_flag <= 1'b0;
      case (r_state)
        IDLE: begin
          if (Shift_Enable) begin
            r_work <= w_operand;
            r_fun  <= ALU_FUN;
            if (w_bypass) begin
              r_out  <= w_operand;
              r_flag <= 1'b1;
`ifdef SHIFT_CARRY_EN
              r_carry <= 1'b0;
`endif
            end else begin
              r_rem   <= SHAMT;
              r_busy  <= 1'b1;
              r_state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          r_work <= w_next;
          r_rem  <= r_rem - w_k;
          if (w_last) begin
            r_out   <= w_next;
            r_flag  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
`ifdef SHIFT_CARRY_EN
            r_carry <= w_carry;
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign Shift_OUT  = r_out;
  assign Shift_Flag = r_flag;
  assign Busy       = r_busy;

endmodule

// File: tb/tb_shift_seq_unit.sv
// Bench for shift_seq_unit: STEP=1 and STEP=4 instances checked against a one-shot arithmetic model.
module tb_shift_seq_unit;

  logic        CLK;
  logic        RST;
  logic [15:0] A;
  logic [15:0] B;
  logic        OP_SEL;
  logic [2:0]  ALU_FUN;
  logic [3:0]  SHAMT;
  logic        en1, en4;
  logic [15:0] out1, out4;
  logic        flag1, flag4, busy1, busy4;
`ifdef SHIFT_CARRY_EN
  logic        carry1, carry4;
`endif

  int vectors     = 0;
  int miscompares = 0;
  logic [15:0] last1, last4;

  shift_seq_unit #(.DATA_WIDTH(16), .STEP(1)) u_s1 (
    .CLK(CLK), .RST(RST), .A(A), .B(B), .OP_SEL(OP_SEL), .ALU_FUN(ALU_FUN),
    .SHAMT(SHAMT), .Shift_Enable(en1), .Shift_OUT(out1), .Shift_Flag(flag1),
`ifdef SHIFT_CARRY_EN
    .Carry_OUT(carry1),
`endif
    .Busy(busy1)
  );

  shift_seq_unit #(.DATA_WIDTH(16), .STEP(4)) u_s4 (
    .CLK(CLK), .RST(RST), .A(A), .B(B), .OP_SEL(OP_SEL), .ALU_FUN(ALU_FUN),
    .SHAMT(SHAMT), .Shift_Enable(en4), .Shift_OUT(out4), .Shift_Flag(flag4),
`ifdef SHIFT_CARRY_EN
    .Carry_OUT(carry4),
`endif
    .Busy(busy4)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Whole-amount result in one step, straight from the operation definitions.
  function automatic logic [15:0] ref_res(input logic [15:0] op, input logic [2:0] fun, input logic [3:0] s);
    int sh;
    logic signed [15:0] so;
    sh = int'(s);
    so = op;
    if (sh == 0) return op;
    case (fun)
      3'd0: return op >> sh;
      3'd1: return op << sh;
      3'd2: return 16'(so >>> sh);
      3'd3: return (op >> sh) | (op << (16 - sh));
      3'd4: return (op << sh) | (op >> (16 - sh));
      default: return op;
    endcase
  endfunction

  function automatic logic ref_carry(input logic [15:0] op, input logic [2:0] fun, input logic [3:0] s);
    int sh;
    sh = int'(s);
    if (sh == 0) return 1'b0;
    case (fun)
      3'd0, 3'd2, 3'd3: return op[sh-1];
      3'd1, 3'd4:       return op[16-sh];
      default:          return 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] get_out(input int inst);
    return (inst == 4) ? out4 : out1;
  endfunction
  function automatic logic get_flag(input int inst);
    return (inst == 4) ? flag4 : flag1;
  endfunction
  function automatic logic get_busy(input int inst);
    return (inst == 4) ? busy4 : busy1;
  endfunction
`ifdef SHIFT_CARRY_EN
  function automatic logic get_carry(input int inst);
    return (inst == 4) ? carry4 : carry1;
  endfunction
`endif

  task automatic set_en(input int inst, input logic v);
    if (inst == 4) en4 = v;
    else en1 = v;
  endtask

  // One operation; poke keeps Shift_Enable high through completion to show it is ignored.
  task automatic run(input int inst, input logic opsel, input logic [15:0] a, input logic [15:0] b,
                     input logic [2:0] fun, input logic [3:0] s, input bit poke);
    logic [15:0] op, er, prev;
    logic        ec;
    int          step, n;
    op   = opsel ? b : a;
    er   = ref_res(op, fun, s);
    ec   = ref_carry(op, fun, s);
    step = (inst == 4) ? 4 : 1;
    n    = (s == 0 || fun > 3'd4) ? 0 : (int'(s) + step - 1) / step;
    prev = (inst == 4) ? last4 : last1;
    @(negedge CLK);
    A = a; B = b; OP_SEL = opsel; ALU_FUN = fun; SHAMT = s;
    set_en(inst, 1'b1);
    @(posedge CLK); #1;
    if (!poke || n == 0) set_en(inst, 1'b0);
    A = 16'($urandom); B = 16'($urandom); OP_SEL = 1'($urandom);
    ALU_FUN = 3'($urandom); SHAMT = 4'($urandom);
    if (n == 0) begin
      chk("bypass_flag", 16'(get_flag(inst)), 16'd1);
      chk("bypass_out", get_out(inst), er);
      chk("bypass_busy", 16'(get_busy(inst)), 16'd0);
`ifdef SHIFT_CARRY_EN
      chk("bypass_carry", 16'(get_carry(inst)), 16'd0);
`endif
    end else begin
      chk("start_busy", 16'(get_busy(inst)), 16'd1);
      chk("start_flag", 16'(get_flag(inst)), 16'd0);
      for (int i = 1; i <= n; i++) begin
        @(posedge CLK); #1;
        if (i < n) begin
          chk("mid_busy", 16'(get_busy(inst)), 16'd1);
          chk("mid_flag", 16'(get_flag(inst)), 16'd0);
          chk("mid_out_hold", get_out(inst), prev);
        end else begin
          chk("done_flag", 16'(get_flag(inst)), 16'd1);
          chk("done_busy", 16'(get_busy(inst)), 16'd0);
          chk("done_out", get_out(inst), er);
`ifdef SHIFT_CARRY_EN
          chk("done_carry", 16'(get_carry(inst)), 16'(ec));
`endif
        end
      end
      set_en(inst, 1'b0);
    end
    if (inst == 4) last4 = er;
    else last1 = er;
  endtask

  initial begin
    RST = 1'b1; A = '0; B = '0; OP_SEL = 1'b0; ALU_FUN = '0; SHAMT = '0;
    en1 = 1'b0; en4 = 1'b0; last1 = '0; last4 = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_out1", out1, 16'h0000);
    chk("rst_flag1", 16'(flag1), 16'd0);
    chk("rst_busy1", 16'(busy1), 16'd0);
    chk("rst_out4", out4, 16'h0000);
`ifdef SHIFT_CARRY_EN
    chk("rst_carry1", 16'(carry1), 16'd0);
`endif
    @(negedge CLK);
    RST = 1'b0;

    run(1, 1'b0, 16'h8001, 16'h0000, 3'd0, 4'd4, 1'b0);   // LSR 4 -> 0800
    @(posedge CLK); #1;
    chk("pulse_one_cycle", 16'(flag1), 16'd0);
    run(1, 1'b1, 16'h0000, 16'h8000, 3'd2, 4'd15, 1'b1);  // ASR 15 -> FFFF
    run(1, 1'b0, 16'h8001, 16'h0000, 3'd4, 4'd1, 1'b0);   // ROL 1 -> 0003
    run(1, 1'b0, 16'h1234, 16'h0000, 3'd1, 4'd0, 1'b0);
    run(1, 1'b0, 16'h1234, 16'h0000, 3'd7, 4'd5, 1'b0);
    run(4, 1'b0, 16'h0001, 16'h0000, 3'd1, 4'd7, 1'b0);   // STEP=4: 4 then 3
    run(4, 1'b0, 16'hF00F, 16'h0000, 3'd3, 4'd9, 1'b1);

    // Reset in the middle of a shift, with an ignored second start.
    @(negedge CLK);
    A = 16'h00FF; OP_SEL = 1'b0; ALU_FUN = 3'd1; SHAMT = 4'd8; en1 = 1'b1;
    @(posedge CLK); #1;
    en1 = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    en1 = 1'b1;
    @(posedge CLK); #1;
    en1 = 1'b0;
    chk("ignored_start_busy", 16'(busy1), 16'd1);
    chk("ignored_start_out", out1, last1);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    #1;
    chk("abort_out", out1, 16'h0000);
    chk("abort_flag", 16'(flag1), 16'd0);
    chk("abort_busy", 16'(busy1), 16'd0);
    chk("abort_out4", out4, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      chk("abort_no_flag", 16'(flag1), 16'd0);
    end
    @(negedge CLK);
    RST = 1'b0;
    last1 = '0; last4 = '0;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK); #1;
      chk("post_rst_idle_flag", 16'(flag1), 16'd0);
      chk("post_rst_idle_busy", 16'(busy1), 16'd0);
    end
    run(1, 1'b0, 16'h00FF, 16'h0000, 3'd1, 4'd8, 1'b0);

    for (int i = 0; i < 60; i++) begin
      run(($urandom_range(0, 1) == 0) ? 1 : 4, 1'($urandom), 16'($urandom), 16'($urandom),
          3'($urandom_range(0, 7)), 4'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
